// File: rtl/reg100_pkg.sv
// reg100_pkg: shared widths, FSM state and beat-index types for the 100-bit reader
package reg100_pkg;
  localparam int WIDTH = 100;
  localparam int BEAT = 32;
  localparam int NBEATS = (WIDTH + BEAT - 1) / BEAT;
  typedef enum logic {IDLE, SEND} state_t;
  typedef logic [1:0] idx_t;
endpackage

// File: rtl/reg_100_reader_if.sv
// reg_100_reader_if: load/stream signals of the 100-bit reader
// master = producer/consumer side (drives load, in, out_ready); slave = reader side.
// REG100_RD_PARITY_EN adds out_parity.
interface reg_100_reader_if;
  import reg100_pkg::*;
  logic load;
  logic [WIDTH-1:0] in;
  logic busy;
  logic [BEAT-1:0] out_data;
  logic out_valid;
  logic out_ready;
  idx_t out_idx;
  logic out_last;
  logic done;
`ifdef REG100_RD_PARITY_EN
  logic out_parity;
  modport master(output load, in, out_ready, input busy, out_data, out_valid, out_idx, out_last, done, out_parity);
  modport slave(input load, in, out_ready, output busy, out_data, out_valid, out_idx, out_last, done, out_parity);
`else
  modport master(output load, in, out_ready, input busy, out_data, out_valid, out_idx, out_last, done);
  modport slave(input load, in, out_ready, output busy, out_data, out_valid, out_idx, out_last, done);
`endif
endinterface

// File: rtl/reg_100_beat_sel.sv
// reg_100_beat_sel: picks 32-bit beat idx of the held word, zero-padding the top beat
// hold: held word, idx: beat index, beat: selected slice, parity (REG100_RD_PARITY_EN): ^beat
module reg_100_beat_sel
  import reg100_pkg::*;
(
  input  logic [WIDTH-1:0] hold,
  input  idx_t             idx,
`ifdef REG100_RD_PARITY_EN
  output logic             parity,
`endif
  output logic [BEAT-1:0]  beat
);
  logic [NBEATS*BEAT-1:0] padded;
  assign padded = {{(NBEATS*BEAT-WIDTH){1'b0}}, hold};
  assign beat = padded[{idx, 5'd0} +: BEAT];
`ifdef REG100_RD_PARITY_EN
  assign parity = ^beat;
`endif
endmodule

// File: rtl/reg_100_reader.sv
// reg_100_reader: snapshots a 100-bit word on load and streams it LSB-first as 4 x 32-bit beats
// clk, reset (sync, active-high); bus: reg_100_reader_if.slave (load/in, busy, out_* stream, done)
// REG100_RD_PARITY_EN adds out_parity = ^out_data.
module reg_100_reader
  import reg100_pkg::*;
(
  input logic             clk,
  input logic             reset,
  reg_100_reader_if.slave bus
);
  state_t state, state_nx;
  logic [WIDTH-1:0] hold;
  idx_t idx;
  logic send, last, xfer, done_q;
  logic [BEAT-1:0] beat;
  assign send = state == SEND;
  assign last = idx == idx_t'(NBEATS - 1);
  assign xfer = send & bus.out_ready;
  always_comb begin
    state_nx = state;
    if (state == IDLE && bus.load) state_nx = SEND;
    else if (xfer && last) state_nx = IDLE;
  end
  always_ff @(posedge clk) state <= reset ? IDLE : state_nx;
  always_ff @(posedge clk) begin
    if (reset) begin
      hold <= '0;
      idx <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= xfer & last;
      if (state == IDLE && bus.load) begin
        hold <= bus.in;
        idx <= '0;
      end else if (xfer) idx <= idx + 2'd1;
    end
  end
`ifdef REG100_RD_PARITY_EN
  logic parity;
  reg_100_beat_sel u_sel(.hold(hold), .idx(idx), .parity(parity), .beat(beat));
  assign bus.out_parity = send & parity;
`else
  reg_100_beat_sel u_sel(.hold(hold), .idx(idx), .beat(beat));
`endif
  assign bus.busy = send;
  assign bus.out_valid = send;
  assign bus.out_idx = idx;
  assign bus.out_last = send & last;
  assign bus.done = done_q;
  assign bus.out_data = send ? beat : '0;
endmodule
